// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: data width, register addressing and the slot entry.
// rd_onehot decodes a destination into a register-file bit mask.
package wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: two valid/ready source channels in, one register-file write port out,
// plus the pending-destination mask and busy status for the core's hazard logic.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       ex_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  is_write;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic [NUM_REGS-1:0]   pend_mask;
  logic                  busy;

  modport master (
    output ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    input  ex_ready, mem_ready, is_write, wb_addr, wb_data, pend_mask, busy
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    output ex_ready, mem_ready, is_write, wb_addr, wb_data, pend_mask, busy
  );
endinterface

// File: rtl/wb_arbiter_slot.sv
// One-entry holding slot: accepts when empty or being granted, so a source can stream 1/cycle.
// Writes to x0 complete the handshake but leave the slot empty.
module wb_slot
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  output logic                  in_ready,
  input  logic                  grant,
  output wb_entry_t             entry
);
  // Ready never looks at in_valid, only at held state and this cycle's grant.
  assign in_ready = !entry.valid || grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (in_valid && in_ready) begin
      entry.valid <= (in_rd != '0);
      entry.rd    <= in_rd;
      entry.data  <= in_data;
    end else if (grant) begin
      entry.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates EX and MEM writeback slots onto the single register-file write port.
// MEM has priority; EX is forced through after MAX_WAIT consecutive losses.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input logic        clk,
  input logic        rst_n,
  wb_arbiter_if.slave bus
);
  wb_entry_t             ex_entry;
  wb_entry_t             mem_entry;
  logic                  grant_ex;
  logic                  grant_mem;
  logic                  ex_forced;
  logic [3:0]            wait_cnt;
  logic                  wr_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       data_q;
  logic [NUM_REGS-1:0]   mask;

  wb_slot u_ex_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.ex_valid),
    .in_rd    (bus.ex_rd),
    .in_data  (bus.ex_data),
    .in_ready (bus.ex_ready),
    .grant    (grant_ex),
    .entry    (ex_entry)
  );

  wb_slot u_mem_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.mem_valid),
    .in_rd    (bus.mem_rd),
    .in_data  (bus.mem_data),
    .in_ready (bus.mem_ready),
    .grant    (grant_mem),
    .entry    (mem_entry)
  );

  assign ex_forced = (wait_cnt == 4'(MAX_WAIT));
  assign grant_ex  = ex_entry.valid && (!mem_entry.valid || ex_forced);
  assign grant_mem = mem_entry.valid && !grant_ex;

  // Counts consecutive EX losses; once it reaches MAX_WAIT EX wins, which clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (ex_entry.valid && !grant_ex) begin
      wait_cnt <= ex_forced ? wait_cnt : wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (grant_ex) begin
      wr_q   <= 1'b1;
      addr_q <= ex_entry.rd;
      data_q <= ex_entry.data;
    end else if (grant_mem) begin
      wr_q   <= 1'b1;
      addr_q <= mem_entry.rd;
      data_q <= mem_entry.data;
    end else begin
      wr_q   <= 1'b0;
    end
  end

  always_comb begin
    mask = '0;
    if (ex_entry.valid)  mask = mask | rd_onehot(ex_entry.rd);
    if (mem_entry.valid) mask = mask | rd_onehot(mem_entry.rd);
    if (wr_q)            mask = mask | rd_onehot(addr_q);
    mask[0] = 1'b0;
  end

  assign bus.is_write  = wr_q;
  assign bus.wb_addr   = addr_q;
  assign bus.wb_data   = data_q;
  assign bus.pend_mask = mask;
  assign bus.busy      = ex_entry.valid || mem_entry.valid || wr_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter: tests queue expected writes, a monitor pops and compares
// every register-file write; each task also checks handshake and mask behaviour inline.
module tb_wb_arbiter;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   wr_cnt;
  exp_t exp_q[$];

  wb_arbiter_if bus ();

  wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Write monitor: every is_write cycle must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.is_write === 1'b1) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%0d data=%h required none", bus.wb_addr, bus.wb_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.wb_addr !== e.rd || bus.wb_data !== e.data) begin
            failures++;
            $display("FAIL write_order got addr=%0d data=%h required addr=%0d data=%h",
                     bus.wb_addr, bus.wb_data, e.rd, e.data);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic idle_inputs();
    bus.ex_valid  = 1'b0;
    bus.ex_rd     = '0;
    bus.ex_data   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.is_write !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_out got we=%b addr=%0d data=%h required 0/0/0", bus.is_write, bus.wb_addr, bus.wb_data);
    end
    checks++;
    if (bus.pend_mask !== 32'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got mask=%h busy=%b required 0/0", bus.pend_mask, bus.busy);
    end
    checks++;
    if (bus.ex_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got ex=%b mem=%b required 1/1", bus.ex_ready, bus.mem_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_ex();
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd5;
    bus.ex_data  = 32'hDEADBEEF;
    checks++;
    if (bus.ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got %b required 1", bus.ex_ready);
    end
    push(5'd5, 32'hDEADBEEF);
    step();
    bus.ex_valid = 1'b0;
    checks++;
    if (bus.is_write !== 1'b0 || bus.pend_mask !== 32'h0000_0020) begin
      failures++;
      $display("FAIL single_c1 got we=%b mask=%h required 0/00000020", bus.is_write, bus.pend_mask);
    end
    step();
    checks++;
    if (bus.is_write !== 1'b1 || bus.pend_mask !== 32'h0000_0020) begin
      failures++;
      $display("FAIL single_c2 got we=%b mask=%h required 1/00000020", bus.is_write, bus.pend_mask);
    end
    step();
    checks++;
    if (bus.is_write !== 1'b0 || bus.pend_mask !== 32'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_c3 got we=%b mask=%h busy=%b required 0/0/0", bus.is_write, bus.pend_mask, bus.busy);
    end
    drain("single");
  endtask

  task automatic test_x0_drop();
    int w0;
    w0 = wr_cnt;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 32'h1234;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready got %b required 1", bus.mem_ready);
    end
    step();
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.pend_mask !== 32'd0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL x0_status got mask=%h busy=%b required 0/0", bus.pend_mask, bus.busy);
      end
      step();
    end
    checks++;
    if (wr_cnt !== w0) begin
      failures++;
      $display("FAIL x0_writes got %0d required %0d", wr_cnt, w0);
    end
  endtask

  task automatic test_contention();
    int mi;
    int ei;
    logic mhs;
    logic ehs;
    logic exp_rdy;
    mi = 1;
    ei = 0;
    for (int k = 1; k <= 4; k++) push(5'(k), 32'h100 + k);
    push(5'd2, 32'h200);
    for (int k = 5; k <= 8; k++) push(5'(k), 32'h100 + k);
    push(5'd2, 32'h201);
    push(5'd9, 32'h109);
    push(5'd2, 32'h202);
    for (int c = 0; c <= 10; c++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(mi);
      bus.mem_data  = 32'h100 + mi;
      bus.ex_valid  = 1'b1;
      bus.ex_rd     = 5'd2;
      bus.ex_data   = 32'h200 + ei;
      exp_rdy = (c % 5 == 0);
      checks++;
      if (bus.ex_ready !== exp_rdy) begin
        failures++;
        $display("FAIL cont_ex_ready c=%0d got %b required %b", c, bus.ex_ready, exp_rdy);
      end
      checks++;
      if (bus.mem_ready !== !(exp_rdy && c > 0)) begin
        failures++;
        $display("FAIL cont_mem_ready c=%0d got %b required %b", c, bus.mem_ready, !(exp_rdy && c > 0));
      end
      mhs = bus.mem_ready;
      ehs = bus.ex_ready;
      step();
      if (mhs) mi++;
      if (ehs) ei++;
    end
    idle_inputs();
    drain("contention");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(i);
      bus.mem_data  = 32'h800 + i;
      checks++;
      if (bus.mem_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready i=%0d got %b required 1", i, bus.mem_ready);
      end
      push(5'(i), 32'h800 + i);
      step();
      if (i >= 2) begin
        checks++;
        if (bus.is_write !== 1'b1 || bus.wb_addr !== 5'(i - 1)) begin
          failures++;
          $display("FAIL b2b_stream i=%0d got we=%b addr=%0d required 1/%0d", i, bus.is_write, bus.wb_addr, i - 1);
        end
      end
    end
    bus.mem_valid = 1'b0;
    step();
    checks++;
    if (bus.is_write !== 1'b1 || bus.wb_addr !== 5'd8) begin
      failures++;
      $display("FAIL b2b_last got we=%b addr=%0d required 1/8", bus.is_write, bus.wb_addr);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    int w0;
    bus.ex_valid  = 1'b1;
    bus.ex_rd     = 5'd10;
    bus.ex_data   = 32'hAAAA;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd11;
    bus.mem_data  = 32'hBBBB;
    step();
    idle_inputs();
    w0 = wr_cnt;
    checks++;
    if (bus.pend_mask !== 32'h0000_0C00 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_full got mask=%h busy=%b required 00000c00/1", bus.pend_mask, bus.busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.is_write !== 1'b0 || bus.pend_mask !== 32'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_clear got we=%b mask=%h busy=%b required 0/0/0", bus.is_write, bus.pend_mask, bus.busy);
    end
    step();
    step();
    step();
    checks++;
    if (wr_cnt !== w0) begin
      failures++;
      $display("FAIL rmid_discard got writes=%0d required %0d", wr_cnt - w0, 0);
    end
  endtask

  task automatic test_backpressure();
    int mi;
    int ei;
    int lows;
    int x7;
    logic mhs;
    logic ehs;
    logic [4:0]  ex_rds [2];
    logic [31:0] ex_dat [2];
    ex_rds[0] = 5'd7;
    ex_rds[1] = 5'd12;
    ex_dat[0] = 32'h77;
    ex_dat[1] = 32'hCC;
    mi = 1;
    ei = 0;
    lows = 0;
    x7 = 0;
    for (int k = 1; k <= 4; k++) push(5'(k), 32'h300 + k);
    push(5'd7, 32'h77);
    push(5'd5, 32'h305);
    push(5'd12, 32'hCC);
    for (int c = 0; c < 10; c++) begin
      bus.mem_valid = (mi <= 5);
      bus.mem_rd    = 5'(mi);
      bus.mem_data  = 32'h300 + mi;
      bus.ex_valid  = (ei < 2);
      bus.ex_rd     = ex_rds[(ei < 2) ? ei : 0];
      bus.ex_data   = ex_dat[(ei < 2) ? ei : 0];
      if (ei == 1 && !bus.ex_ready) begin
        lows++;
        checks++;
        if (bus.pend_mask[7] !== 1'b1) begin
          failures++;
          $display("FAIL bp_pend7 c=%0d got %b required 1", c, bus.pend_mask[7]);
        end
      end
      mhs = bus.mem_valid && bus.mem_ready;
      ehs = bus.ex_valid && bus.ex_ready;
      step();
      if (bus.is_write === 1'b1 && bus.wb_addr === 5'd7) x7++;
      if (mhs) mi++;
      if (ehs) ei++;
    end
    idle_inputs();
    checks++;
    if (lows !== 4) begin
      failures++;
      $display("FAIL bp_stall_cycles got %0d required 4", lows);
    end
    checks++;
    if (x7 !== 1) begin
      failures++;
      $display("FAIL bp_x7_writes got %0d required 1", x7);
    end
    drain("backpressure");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_single_ex();
    test_x0_drop();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
